dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store initiator for the word-addressed data memory in the MEM stage.
- Accepts one RV32I load/store request at a time: LB, LH, LW, LBU, LHU, SB, SH, SW.
- Drives the memory's write-enable, address and write-data, and sign/zero-extends load data.
- Memory writes whole words only, so SB/SH use a read-modify-write sequence.
- Busy back-pressure (req_ready low) stalls the pipeline.

Parameters:
MEM_WORDS, 256, memory depth in 32-bit words; word index = addr[log2(MEM_WORDS)+1:2].
CHECK_RANGE, 1, 1 = addresses >= 4*MEM_WORDS return err with no memory access; 0 = upper bits ignored (aliasing).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset, asynchronous, active-low.
req_valid  input  1  request present; sampled only when req_ready=1.
req_ready  output  1  high only in IDLE.
req_we  input  1  1 = store, 0 = load.
req_funct3  input  3  RV32I funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; other codes -> err.
req_addr  input  32  byte address.
req_wdata  input  32  store data; low byte/half used for SB/SH.
resp_valid  output  1  one-cycle pulse: request complete.
resp_rdata  output  32  extended load data; 0 for stores and errors; held until next resp_valid.
resp_err  output  1  misaligned, out-of-range or illegal funct3; valid with resp_valid.
mem_rw  output  1  memory write enable (1 = write, 0 = read).
mem_addr  output  32  memory byte address.
mem_wdata  output  32  memory write data.
mem_rdata  input  32  combinational read data for mem_addr.

Behaviour:
- Reset (async, rst_n=0):
  - State returns to IDLE.
  - mem_rw=0 immediately, not at the next edge.
  - resp_valid=0, resp_err=0, resp_rdata=0, mem_addr=0, mem_wdata=0, req_ready=1 once released.
- Reset mid-operation aborts the operation: no write, no response.
- Invariant: mem_rw=1 only in a write cycle, for exactly one clock per store.
- Byte lanes are little-endian: byte k = bits [8k+7:8k], k = addr[1:0]; half k = addr[1].
- State IDLE (req_ready=1); on req_valid, latch addr, funct3, wdata and classify:
  - Error if any of these hold: H/HU with addr[0]=1; W with addr[1:0]!=0; illegal funct3; CHECK_RANGE=1 and out of range.
    - mem_rw=0. Set err_q=1, rdata_q=0. Go to RESP.
  - Load:
    - mem_addr=req_addr, mem_rw=0 combinationally this cycle.
    - At the edge, rdata_q = selected lane of mem_rdata, sign-extended (B/H) or zero-extended (BU/HU/W). Go to RESP.
  - SW: mem_rw=1, mem_wdata=req_wdata this cycle. The word is written at the edge. Go to RESP.
  - SB/SH: mem_rw=0, mem_addr=req_addr. Capture mem_rdata into merge_q at the edge. Go to RMW_WR.
- State RMW_WR (req_ready=0):
  - mem_addr=addr_q, mem_rw=1.
  - mem_wdata = merge_q with the target byte/half lane replaced by wdata_q[7:0] or wdata_q[15:0].
  - Go to RESP.
- State RESP (req_ready=0): resp_valid=1 for this one cycle, outputs from rdata_q/err_q, mem_rw=0. Go to IDLE.
- Latency from the accept edge to resp_valid:
  - Load, SW, error: resp_valid is high the cycle after the accept edge.
  - SB/SH: resp_valid is high two cycles after the accept edge.
- Throughput: one request per 2 cycles (loads/SW/errors), one per 3 cycles (SB/SH).
- req_valid while req_ready=0 is ignored; the requester holds it.
- Inputs latched at accept; later changes are ignored until the next IDLE.

Test Plan:
- SW addr 0x10 data 0x8899AABB -> mem_rw high exactly 1 cycle; resp_valid next cycle, err=0, rdata=0. Then LW 0x10 -> rdata 0x8899AABB.
- With word 0x10 = 0x8899AABB:
  - LB 0x13 -> 0xFFFFFF88.
  - LBU 0x13 -> 0x00000088.
  - LH 0x12 -> 0xFFFF8899.
  - LHU 0x10 -> 0x0000AABB.
  - LB 0x10 -> 0xFFFFFFBB.
- SB 0x11 data 0x123456CC -> one read cycle, one write cycle, word becomes 0x8899CCBB. SH 0x12 data 0x00007777 -> word 0x7777CCBB. resp_valid 2 cycles after accept.
- Errors, each resp_err=1 with mem_rw never high:
  - LW 0x12.
  - SH 0x11.
  - funct3=011.
  - LW 0x400 with MEM_WORDS=256.
- Async reset asserted mid-cycle during RMW_WR of SB 0x10 -> mem_rw falls without a clock edge, word unchanged, no resp_valid. After release, req_ready=1.
- Back-to-back: req_valid held continuously with SW then LW -> second request accepted only when req_ready=1. Exactly one resp_valid per request, in order.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: MEM-stage load/store initiator for a word-wide data memory.
// Loads and SW complete in one memory cycle. SB/SH read the word, merge
// the new lane in and write it back. One request is in flight at a time,
// and req_ready throttles the requester.
module dmem_lsu #(
    parameter int MEM_WORDS   = 256,
    parameter bit CHECK_RANGE = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RMW_WR = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [2:0]  funct3_q;
    logic [31:0] rdata_q;
    logic        err_q;
    logic        resp_valid_q;

    logic        req_err_s;
    logic        mem_rw_s;
    logic [31:0] mem_addr_s;
    logic [31:0] mem_wdata_s;

    // The access is illegal if the funct3 code is invalid, the address is misaligned, or the address is out of range.
    function automatic logic classify_err(input logic        we,
                                          input logic [2:0]  f3,
                                          input logic [31:0] addr);
        logic bad;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = addr[0];
            F3_W:    bad = (addr[1:0] != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | addr[0];
            default: bad = 1'b1;
        endcase
        if (CHECK_RANGE && ((addr >> (AW + 2)) != 32'd0)) begin
            bad = 1'b1;
        end else begin
            bad = bad;
        end
        return bad;
    endfunction

    // Select the addressed byte/half lane and extend it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                                input logic [1:0]  off,
                                                input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    return {{24{b[7]}}, b};
            F3_H:    return {{16{h[15]}}, h};
            F3_W:    return word;
            F3_BU:   return {24'd0, b};
            F3_HU:   return {16'd0, h};
            default: return 32'd0;
        endcase
    endfunction

    // Put the store byte/half into its lane of the word that was read.
    function automatic logic [31:0] merge_lane(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] word,
                                               input logic [31:0] wd);
        logic [31:0] m;
        m = word;
        if (f3 == F3_B) begin
            m[{off, 3'b000} +: 8] = wd[7:0];
        end else if (off[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        return m;
    endfunction

    assign req_err_s = classify_err(req_we, req_funct3, req_addr);

    // Memory-side drive: combinational in IDLE, so a load or SW completes in the accept cycle; forced idle during reset.
    always_comb begin
        mem_rw_s    = 1'b0;
        mem_addr_s  = 32'd0;
        mem_wdata_s = 32'd0;
        if (!rst_n) begin
            mem_rw_s    = 1'b0;
            mem_addr_s  = 32'd0;
            mem_wdata_s = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid && !req_err_s) begin
                        mem_addr_s = req_addr;
                        if (req_we && (req_funct3 == F3_W)) begin
                            mem_rw_s    = 1'b1;
                            mem_wdata_s = req_wdata;
                        end else begin
                            mem_rw_s    = 1'b0;
                            mem_wdata_s = 32'd0;
                        end
                    end else begin
                        mem_addr_s = 32'd0;
                    end
                end
                ST_RMW_WR: begin
                    mem_rw_s    = 1'b1;
                    mem_addr_s  = addr_q;
                    mem_wdata_s = merge_lane(funct3_q, addr_q[1:0], merge_q, wdata_q);
                end
                ST_RESP: begin
                    mem_rw_s = 1'b0;
                end
                default: begin
                    mem_rw_s = 1'b0;
                end
            endcase
        end
    end

    // Control FSM: accept and classify in IDLE, write back the merged word in RMW_WR, pulse the response in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            merge_q      <= 32'd0;
            funct3_q     <= 3'd0;
            rdata_q      <= 32'd0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    resp_valid_q <= 1'b0;
                    if (req_valid) begin
                        addr_q   <= req_addr;
                        funct3_q <= req_funct3;
                        wdata_q  <= req_wdata;
                        if (req_err_s) begin
                            err_q        <= 1'b1;
                            rdata_q      <= 32'd0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if (!req_we) begin
                            err_q        <= 1'b0;
                            rdata_q      <= load_extend(req_funct3, req_addr[1:0], mem_rdata);
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else if (req_funct3 == F3_W) begin
                            err_q        <= 1'b0;
                            rdata_q      <= 32'd0;
                            resp_valid_q <= 1'b1;
                            state_q      <= ST_RESP;
                        end else begin
                            merge_q <= mem_rdata;
                            state_q <= ST_RMW_WR;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RMW_WR: begin
                    err_q        <= 1'b0;
                    rdata_q      <= 32'd0;
                    resp_valid_q <= 1'b1;
                    state_q      <= ST_RESP;
                end
                ST_RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
                default: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_rw     = mem_rw_s;
    assign mem_addr   = mem_addr_s;
    assign mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed testbench for dmem_lsu. It uses a 256-word behavioural memory
// with combinational reads and edge-triggered writes.
module tb_dmem_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];
    int          wr_cnt   = 0;
    int          resp_cnt = 0;
    int          n_cmp    = 0;
    int          n_err    = 0;
    int          exp_resp = 0;

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          nwr;
    int          r0;

    dmem_lsu #(.MEM_WORDS(256), .CHECK_RANGE(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_rw     (mem_rw),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[9:2]];

    // Memory model: write the word on the edge and count write cycles and response pulses.
    always @(posedge clk) begin
        if (mem_rw) begin
            mem[mem_addr[9:2]] <= mem_wdata;
            wr_cnt <= wr_cnt + 1;
        end
        if (resp_valid) begin
            resp_cnt <= resp_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request from IDLE. Return the response, its latency in negedges after accept, and the number of write cycles.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic [31:0] o_rd, output logic o_er,
                          output int o_lat, output int o_nwr);
        int w0;
        @(negedge clk);
        w0         = wr_cnt;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wd;
        exp_resp++;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5A5A_5A5A;
        o_lat = 1;
        while (!resp_valid && o_lat < 8) begin
            @(negedge clk);
            o_lat++;
        end
        o_rd  = resp_rdata;
        o_er  = resp_err;
        o_nwr = wr_cnt - w0;
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0010;
        req_wdata  = 32'hDEAD_BEEF;
        #3;
        check("rst_mem_rw", {31'd0, mem_rw}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);

        // SW, then read it back
        do_req(1'b1, 3'b010, 32'h10, 32'h8899AABB, rd, er, lat, nwr);
        check("sw_lat", lat, 32'd1);
        check("sw_writes", nwr, 32'd1);
        check("sw_err", {31'd0, er}, 32'd0);
        check("sw_rdata", rd, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nwr);
        check("lw_lat", lat, 32'd1);
        check("lw_rdata", rd, 32'h8899AABB);
        check("lw_writes", nwr, 32'd0);

        // Sub-word loads
        do_req(1'b0, 3'b000, 32'h13, 32'h0, rd, er, lat, nwr);
        check("lb_13", rd, 32'hFFFFFF88);
        do_req(1'b0, 3'b100, 32'h13, 32'h0, rd, er, lat, nwr);
        check("lbu_13", rd, 32'h00000088);
        do_req(1'b0, 3'b001, 32'h12, 32'h0, rd, er, lat, nwr);
        check("lh_12", rd, 32'hFFFF8899);
        do_req(1'b0, 3'b101, 32'h10, 32'h0, rd, er, lat, nwr);
        check("lhu_10", rd, 32'h0000AABB);
        do_req(1'b0, 3'b000, 32'h10, 32'h0, rd, er, lat, nwr);
        check("lb_10", rd, 32'hFFFFFFBB);
        check("lb_10_err", {31'd0, er}, 32'd0);

        // Read-modify-write stores
        do_req(1'b1, 3'b000, 32'h11, 32'h123456CC, rd, er, lat, nwr);
        check("sb_lat", lat, 32'd2);
        check("sb_writes", nwr, 32'd1);
        check("sb_err", {31'd0, er}, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nwr);
        check("sb_word", rd, 32'h8899CCBB);
        do_req(1'b1, 3'b001, 32'h12, 32'h00007777, rd, er, lat, nwr);
        check("sh_lat", lat, 32'd2);
        check("sh_writes", nwr, 32'd1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nwr);
        check("sh_word", rd, 32'h7777CCBB);

        // Error cases
        do_req(1'b0, 3'b010, 32'h12, 32'h0, rd, er, lat, nwr);
        check("err_lw12", {31'd0, er}, 32'd1);
        check("err_lw12_lat", lat, 32'd1);
        check("err_lw12_rdata", rd, 32'd0);
        do_req(1'b1, 3'b001, 32'h11, 32'hFFFF, rd, er, lat, nwr);
        check("err_sh11", {31'd0, er}, 32'd1);
        check("err_sh11_writes", nwr, 32'd0);
        do_req(1'b0, 3'b011, 32'h10, 32'h0, rd, er, lat, nwr);
        check("err_f3_011", {31'd0, er}, 32'd1);
        do_req(1'b0, 3'b010, 32'h400, 32'h0, rd, er, lat, nwr);
        check("err_range", {31'd0, er}, 32'd1);
        check("err_range_writes", nwr, 32'd0);
        do_req(1'b1, 3'b010, 32'h400, 32'h11111111, rd, er, lat, nwr);
        check("err_range_sw_writes", nwr, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nwr);
        check("err_no_alias_write", rd, 32'h7777CCBB);

        // Async reset during RMW_WR aborts the store
        @(negedge clk);
        r0         = resp_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b000;
        req_addr   = 32'h10;
        req_wdata  = 32'h000000EE;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_rmw_rw", {31'd0, mem_rw}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_rw_fall", {31'd0, mem_rw}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        check("abort_no_resp", resp_cnt - r0, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat, nwr);
        check("abort_word", rd, 32'h7777CCBB);

        // Back-to-back requests with req_valid held high
        @(negedge clk);
        r0         = resp_cnt;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h20;
        req_wdata  = 32'h11223344;
        exp_resp   = exp_resp + 2;
        @(posedge clk);
        @(negedge clk);
        req_we     = 1'b0;
        req_wdata  = 32'h0;
        check("b2b_sw_resp", {31'd0, resp_valid}, 32'd1);
        check("b2b_busy", {31'd0, req_ready}, 32'd0);
        check("b2b_busy_rw", {31'd0, mem_rw}, 32'd0);
        @(negedge clk);
        check("b2b_ready", {31'd0, req_ready}, 32'd1);
        check("b2b_no_resp", {31'd0, resp_valid}, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        check("b2b_lw_resp", {31'd0, resp_valid}, 32'd1);
        check("b2b_lw_rdata", resp_rdata, 32'h11223344);
        @(negedge clk);
        check("b2b_resp_count", resp_cnt - r0, 32'd2);
        @(negedge clk);
        check("total_resp", resp_cnt, exp_resp);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
